// File: rtl/apix_receiver.sv
// APIX serial receiver: hunts for the sync byte, then deserializes a fixed-length
// frame of 24-bit RGB pixels and checks the trailing XOR CRC byte.
module apix_receiver #(
  parameter logic [7:0] SYNC_BYTE        = 8'hFF,
  parameter int         PIXELS_PER_FRAME = 1080,
  parameter int         CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             apix_data,
  input  logic             apix_data_valid,
  output logic [23:0]      pixel_data,
  output logic             pixel_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             crc_error,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] error_count
);

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] PIXEL = 2'd1;
  localparam logic [1:0] CRC   = 2'd2;

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXELS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       window_q, window_d;
  logic [2:0]       bitCnt_q, bitCnt_d;
  logic [1:0]       byteIdx_q, byteIdx_d;
  logic [CNT_W-1:0] pixCnt_q, pixCnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       red_q, red_d;
  logic [7:0]       green_q, green_d;
  logic [23:0]      pixelData_q, pixelData_d;
  logic             pixelValid_q, pixelValid_d;
  logic             frameStart_q, frameStart_d;
  logic             frameDone_q, frameDone_d;
  logic             crcError_q, crcError_d;
  logic [CNT_W-1:0] frameCount_q, frameCount_d;
  logic [CNT_W-1:0] errorCount_q, errorCount_d;

  logic [7:0] shifted;
  logic       byteDone;

  // The window doubles as the byte assembler once synced: after 8 bits it holds the byte.
  assign shifted  = {window_q[6:0], apix_data};
  assign byteDone = (bitCnt_q == 3'd7);

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    bitCnt_d     = bitCnt_q;
    byteIdx_d    = byteIdx_q;
    pixCnt_d     = pixCnt_q;
    crc_d        = crc_q;
    red_d        = red_q;
    green_d      = green_q;
    pixelData_d  = pixelData_q;
    pixelValid_d = 1'b0;
    frameStart_d = 1'b0;
    frameDone_d  = 1'b0;
    crcError_d   = 1'b0;
    frameCount_d = frameCount_q;
    errorCount_d = errorCount_q;

    if (apix_data_valid) begin
      window_d = shifted;
      case (state_q)
        HUNT: begin
          if (shifted == SYNC_BYTE) begin
            state_d      = PIXEL;
            frameStart_d = 1'b1;
            bitCnt_d     = 3'd0;
            byteIdx_d    = 2'd0;
            pixCnt_d     = '0;
            crc_d        = 8'd0;
          end
        end
        PIXEL: begin
          bitCnt_d = bitCnt_q + 3'd1;
          if (byteDone) begin
            crc_d = crc_q ^ shifted;
            case (byteIdx_q)
              2'd0: begin
                red_d     = shifted;
                byteIdx_d = 2'd1;
              end
              2'd1: begin
                green_d   = shifted;
                byteIdx_d = 2'd2;
              end
              default: begin
                pixelData_d  = {red_q, green_q, shifted};
                pixelValid_d = 1'b1;
                byteIdx_d    = 2'd0;
                pixCnt_d     = pixCnt_q + CNT_ONE;
                if (pixCnt_q == PIX_LAST) begin
                  state_d = CRC;
                end
              end
            endcase
          end
        end
        CRC: begin
          bitCnt_d = bitCnt_q + 3'd1;
          if (byteDone) begin
            frameDone_d = 1'b1;
            if (shifted != crc_q) begin
              crcError_d = 1'b1;
              if (errorCount_q != '1) begin
                errorCount_d = errorCount_q + CNT_ONE;
              end
            end else begin
              frameCount_d = frameCount_q + CNT_ONE;
            end
            // A fresh, fully shifted-in sync byte is needed for the next frame.
            state_d  = HUNT;
            window_d = 8'd0;
          end
        end
        default: begin
          state_d  = HUNT;
          window_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      window_q      <= 8'd0;
      bitCnt_q      <= 3'd0;
      byteIdx_q     <= 2'd0;
      pixCnt_q      <= '0;
      crc_q         <= 8'd0;
      red_q         <= 8'd0;
      green_q       <= 8'd0;
      pixelData_q   <= 24'd0;
      pixelValid_q  <= 1'b0;
      frameStart_q  <= 1'b0;
      frameDone_q   <= 1'b0;
      crcError_q    <= 1'b0;
      frameCount_q  <= '0;
      errorCount_q  <= '0;
    end else begin
      state_q       <= state_d;
      window_q      <= window_d;
      bitCnt_q      <= bitCnt_d;
      byteIdx_q     <= byteIdx_d;
      pixCnt_q      <= pixCnt_d;
      crc_q         <= crc_d;
      red_q         <= red_d;
      green_q       <= green_d;
      pixelData_q   <= pixelData_d;
      pixelValid_q  <= pixelValid_d;
      frameStart_q  <= frameStart_d;
      frameDone_q   <= frameDone_d;
      crcError_q    <= crcError_d;
      frameCount_q  <= frameCount_d;
      errorCount_q  <= errorCount_d;
    end
  end

  assign pixel_data  = pixelData_q;
  assign pixel_valid = pixelValid_q;
  assign frame_start = frameStart_q;
  assign frame_done  = frameDone_q;
  assign crc_error   = crcError_q;
  assign frame_count = frameCount_q;
  assign error_count = errorCount_q;

endmodule

// File: tb/tb_apix_receiver.sv
// Bench for apix_receiver: table of whole frames, hand-timed corner sequences and
// randomized streams, all compared against a bit-stream frame parser model.
module tb_apix_receiver;

  localparam int PPF = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic apix_data;
  logic apix_data_valid;

  logic [23:0] pdA, pdB;
  logic        pvA, pvB, fsA, fsB, fdA, fdB, ceA, ceB;
  logic [15:0] fcA, ecA;
  logic [1:0]  fcB, ecB;

  always #5 clk = ~clk;

  apix_receiver #(.SYNC_BYTE(8'hFF), .PIXELS_PER_FRAME(PPF), .CNT_W(16)) dutA (
    .clk(clk), .rst_n(rst_n), .apix_data(apix_data), .apix_data_valid(apix_data_valid),
    .pixel_data(pdA), .pixel_valid(pvA), .frame_start(fsA), .frame_done(fdA),
    .crc_error(ceA), .frame_count(fcA), .error_count(ecA)
  );

  apix_receiver #(.SYNC_BYTE(8'hFF), .PIXELS_PER_FRAME(PPF), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .apix_data(apix_data), .apix_data_valid(apix_data_valid),
    .pixel_data(pdB), .pixel_valid(pvB), .frame_start(fsB), .frame_done(fdB),
    .crc_error(ceB), .frame_count(fcB), .error_count(ecB)
  );

  typedef struct {
    bit err;
    int fc;
    int ec;
  } doneEvt_t;

  typedef struct {
    int          garbLen;
    logic [7:0]  garb;
    logic [7:0]  bytes [8];
    int          mode;
    int          gapAt;
    logic [23:0] pix0;
    logic [23:0] pix1;
    bit          err;
    int          fc;
    int          ec;
  } vec_t;

  int checks = 0;
  int failures = 0;

  bit          streamQ[$];
  bit          txQ[$];
  logic [23:0] obsPixA[$], obsPixB[$];
  doneEvt_t    obsDoneA[$], obsDoneB[$];
  int          startsA = 0, startsB = 0, strayA = 0, strayB = 0;
  int          pixVerified = 0, doneVerified = 0;

  logic [23:0] expPix[$];
  bit          expErr[$];
  int          expStarts;

  // Output monitor: every pulse seen on a falling edge is one event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pvA) obsPixA.push_back(pdA);
      if (pvB) obsPixB.push_back(pdB);
      if (fsA) startsA++;
      if (fsB) startsB++;
      if (fdA) obsDoneA.push_back('{err: ceA, fc: int'(fcA), ec: int'(ecA)});
      if (fdB) obsDoneB.push_back('{err: ceB, fc: int'(fcB), ec: int'(ecB)});
      if (ceA && !fdA) strayA++;
      if (ceB && !fdB) strayB++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    apix_data_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendBit(input bit b);
    apix_data       = b;
    apix_data_valid = 1'b1;
    @(posedge clk);
    #1;
    apix_data_valid = 1'b0;
    apix_data       = 1'($urandom);
    streamQ.push_back(b);
  endtask

  task automatic addByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) txQ.push_back(b[i]);
  endtask

  task automatic addBits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) txQ.push_back(v[i]);
  endtask

  // mode 0: continuous, 1: valid toggles, 2: random idle cycles; gapAt inserts 20 idle cycles.
  task automatic applyStimulus(input int mode, input int gapAt);
    for (int i = 0; i < txQ.size(); i++) begin
      if (i == gapAt) idle(20);
      sendBit(txQ[i]);
      if (mode == 1) idle(1);
      else if (mode == 2) idle($urandom_range(0, 2));
    end
    txQ.delete();
  endtask

  task automatic doReset();
    idle(2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    streamQ.delete();
    obsPixA.delete();
    obsPixB.delete();
    obsDoneA.delete();
    obsDoneB.delete();
    startsA = 0;
    startsB = 0;
    strayA = 0;
    strayB = 0;
    pixVerified = 0;
    doneVerified = 0;
    checkOutput("rstPixelData", pdA, 0);
    checkOutput("rstPulses", {pvA, fsA, fdA, ceA, pvB, fsB, fdB, ceB}, 0);
    checkOutput("rstFrameCount", fcA, 0);
    checkOutput("rstErrorCount", ecA, 0);
    checkOutput("rstCountsB", {fcB, ecB}, 0);
  endtask

  function automatic int getBits(input int pos, input int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(streamQ[pos + i]);
    return v;
  endfunction

  // Parses the whole bit stream since reset: find an 0xFF run of 8 fresh bits,
  // then PPF 24-bit pixels, then the CRC byte compared with the XOR of pixel bytes.
  task automatic modelCompute();
    int n = streamQ.size();
    int huntStart = 0;
    expPix.delete();
    expErr.delete();
    expStarts = 0;
    while (1) begin
      int syncEnd = -1;
      int q;
      int crc = 0;
      bit complete = 1;
      for (int p = huntStart + 8; p <= n; p++) begin
        if (getBits(p - 8, 8) == 8'hFF) begin
          syncEnd = p;
          break;
        end
      end
      if (syncEnd < 0) break;
      expStarts++;
      q = syncEnd;
      for (int k = 0; k < PPF; k++) begin
        int pix;
        if (q + 24 > n) begin
          complete = 0;
          break;
        end
        pix = getBits(q, 24);
        crc = crc ^ (pix / 65536) ^ ((pix / 256) % 256) ^ (pix % 256);
        expPix.push_back(24'(pix));
        q += 24;
      end
      if (!complete || q + 8 > n) break;
      expErr.push_back(getBits(q, 8) != crc);
      huntStart = q + 8;
    end
  endtask

  task automatic verify(input string tag);
    int good = 0;
    int bad = 0;
    modelCompute();
    checkOutput({tag, " startsA"}, startsA, expStarts);
    checkOutput({tag, " startsB"}, startsB, expStarts);
    checkOutput({tag, " pixCountA"}, obsPixA.size(), expPix.size());
    checkOutput({tag, " pixCountB"}, obsPixB.size(), expPix.size());
    for (int i = pixVerified; i < expPix.size(); i++) begin
      if (i < obsPixA.size()) checkOutput($sformatf("%s pixA[%0d]", tag, i), obsPixA[i], expPix[i]);
      if (i < obsPixB.size()) checkOutput($sformatf("%s pixB[%0d]", tag, i), obsPixB[i], expPix[i]);
    end
    checkOutput({tag, " doneCountA"}, obsDoneA.size(), expErr.size());
    checkOutput({tag, " doneCountB"}, obsDoneB.size(), expErr.size());
    for (int i = 0; i < expErr.size(); i++) begin
      if (expErr[i]) bad++;
      else good++;
      if (i >= doneVerified && i < obsDoneA.size()) begin
        checkOutput($sformatf("%s crcErrA[%0d]", tag, i), obsDoneA[i].err, expErr[i]);
        checkOutput($sformatf("%s frameCntA[%0d]", tag, i), obsDoneA[i].fc, good % 65536);
        checkOutput($sformatf("%s errCntA[%0d]", tag, i), obsDoneA[i].ec, (bad > 65535) ? 65535 : bad);
      end
      if (i >= doneVerified && i < obsDoneB.size()) begin
        checkOutput($sformatf("%s crcErrB[%0d]", tag, i), obsDoneB[i].err, expErr[i]);
        checkOutput($sformatf("%s frameCntB[%0d]", tag, i), obsDoneB[i].fc, good % 4);
        checkOutput($sformatf("%s errCntB[%0d]", tag, i), obsDoneB[i].ec, (bad > 3) ? 3 : bad);
      end
    end
    checkOutput({tag, " strayCrcErr"}, strayA + strayB, 0);
    pixVerified  = expPix.size();
    doneVerified = expErr.size();
  endtask

  vec_t vecs[5];

  initial begin
    logic [31:0] hdr;
    int          fcSeq[6];
    int          sBefore, pBefore, dBefore;

    vecs[0] = '{garbLen: 0, garb: 8'h00, bytes: '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77},
                mode: 0, gapAt: -1, pix0: 24'h112233, pix1: 24'h445566, err: 0, fc: 1, ec: 0};
    vecs[1] = '{garbLen: 0, garb: 8'h00, bytes: '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h78},
                mode: 0, gapAt: -1, pix0: 24'h112233, pix1: 24'h445566, err: 1, fc: 1, ec: 1};
    vecs[2] = '{garbLen: 5, garb: 8'b0001_0100, bytes: '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77},
                mode: 0, gapAt: -1, pix0: 24'h112233, pix1: 24'h445566, err: 0, fc: 2, ec: 1};
    vecs[3] = '{garbLen: 0, garb: 8'h00, bytes: '{8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77},
                mode: 1, gapAt: 20, pix0: 24'h112233, pix1: 24'h445566, err: 0, fc: 3, ec: 1};
    vecs[4] = '{garbLen: 0, garb: 8'h00, bytes: '{8'hFF, 8'hFF, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h99},
                mode: 0, gapAt: -1, pix0: 24'hFF2233, pix1: 24'h445566, err: 0, fc: 4, ec: 1};
    fcSeq = '{1, 2, 3, 0, 1, 2};

    rst_n = 1'b0;
    apix_data = 1'b0;
    apix_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("initPulses", {pvA, fsA, fdA, ceA}, 0);
    checkOutput("initCounts", {fcA, ecA}, 0);

    // Hand-timed: frame_start right after the 8th sync bit, pixel_valid after the 24th pixel bit.
    hdr = 32'hFF112233;
    for (int i = 0; i < 32; i++) begin
      sendBit(hdr[31 - i]);
      if (i == 6) checkOutput("fsBeforeSync", fsA, 0);
      if (i == 7) checkOutput("fsAtSync", fsA, 1);
      if (i == 8) checkOutput("fsOneCycle", fsA, 0);
      if (i == 30) checkOutput("pvEarly", pvA, 0);
      if (i == 31) begin
        checkOutput("pvOnTime", pvA, 1);
        checkOutput("pdOnTime", pdA, 24'h112233);
      end
    end
    idle(3);
    checkOutput("pvOneCycle", pvA, 0);
    checkOutput("pdHolds", pdA, 24'h112233);
    addByte(8'h44); addByte(8'h55); addByte(8'h66); addByte(8'h77);
    applyStimulus(0, -1);
    idle(3);
    checkOutput("handFrameCount", fcA, 1);
    verify("hand");

    doReset();
    for (int v = 0; v < 5; v++) begin
      sBefore = startsA;
      pBefore = obsPixA.size();
      dBefore = obsDoneA.size();
      addBits(vecs[v].garb, vecs[v].garbLen);
      for (int j = 0; j < 8; j++) addByte(vecs[v].bytes[j]);
      applyStimulus(vecs[v].mode, vecs[v].gapAt);
      idle(3);
      checkOutput($sformatf("vec%0d starts", v), startsA - sBefore, 1);
      checkOutput($sformatf("vec%0d pixels", v), obsPixA.size() - pBefore, 2);
      if (obsPixA.size() >= pBefore + 2) begin
        checkOutput($sformatf("vec%0d pix0", v), obsPixA[pBefore], vecs[v].pix0);
        checkOutput($sformatf("vec%0d pix1", v), obsPixA[pBefore + 1], vecs[v].pix1);
      end
      checkOutput($sformatf("vec%0d dones", v), obsDoneA.size() - dBefore, 1);
      if (obsDoneA.size() > dBefore) checkOutput($sformatf("vec%0d crcErr", v), obsDoneA[dBefore].err, vecs[v].err);
      checkOutput($sformatf("vec%0d frameCount", v), fcA, vecs[v].fc);
      checkOutput($sformatf("vec%0d errorCount", v), ecA, vecs[v].ec);
      verify($sformatf("vec%0d", v));
    end

    // Reset mid-frame after the first pixel: the partial frame must vanish silently.
    addByte(8'hFF); addByte(8'h11); addByte(8'h22); addByte(8'h33); addByte(8'h44);
    applyStimulus(0, -1);
    idle(2);
    checkOutput("abortPixels", obsPixA.size() - pixVerified, 1);
    doReset();
    addByte(8'hFF); addByte(8'h11); addByte(8'h22); addByte(8'h33);
    addByte(8'h44); addByte(8'h55); addByte(8'h66); addByte(8'h77);
    applyStimulus(0, -1);
    idle(3);
    checkOutput("afterRstDones", obsDoneA.size(), 1);
    checkOutput("afterRstFrameCount", fcA, 1);
    verify("abort");

    // Narrow counters: frame_count wraps, error_count saturates.
    doReset();
    for (int f = 0; f < 6; f++) begin
      addByte(8'hFF); addByte(8'h11); addByte(8'h22); addByte(8'h33);
      addByte(8'h44); addByte(8'h55); addByte(8'h66); addByte(8'h77);
    end
    applyStimulus(0, -1);
    idle(3);
    checkOutput("wrapDones", obsDoneB.size(), 6);
    for (int f = 0; f < 6; f++) begin
      if (f < obsDoneB.size()) checkOutput($sformatf("wrapFc[%0d]", f), obsDoneB[f].fc, fcSeq[f]);
    end
    for (int f = 0; f < 5; f++) begin
      addByte(8'hFF); addByte(8'h11); addByte(8'h22); addByte(8'h33);
      addByte(8'h44); addByte(8'h55); addByte(8'h66); addByte(8'h78);
    end
    applyStimulus(0, -1);
    idle(3);
    checkOutput("satErrB", ecB, 3);
    checkOutput("satErrA", ecA, 5);
    checkOutput("satFcB", fcB, 2);
    verify("counters");

    // Random frames with random garbage, random gaps and occasional bad CRC.
    doReset();
    for (int f = 0; f < 12; f++) begin
      logic [7:0] b;
      logic [7:0] crc = 8'h00;
      addBits(8'($urandom), $urandom_range(0, 8));
      addByte(8'hFF);
      for (int j = 0; j < 3 * PPF; j++) begin
        b = 8'($urandom);
        crc ^= b;
        addByte(b);
      end
      if ($urandom_range(0, 9) < 3) crc ^= 8'($urandom_range(1, 255));
      addByte(crc);
    end
    applyStimulus(2, -1);
    idle(3);
    verify("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
